// File: rtl/stopwatch_core.sv
// Centisecond stopwatch with up/down BCD counting, preload, sticky done/overflow flags and a lap ring buffer.
// Time updates one cycle after a prescaler tick; lap_bcd is registered with one cycle read latency.
module stopwatch_core #(
  parameter int TICK_DIV  = 500000,
  parameter int LAP_DEPTH = 8,
  localparam int LAP_AW   = $clog2(LAP_DEPTH)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              start_stop_p,
  input  logic              clear_p,
  input  logic              lap_p,
  input  logic              load_p,
  input  logic [23:0]       load_val,
  input  logic              mode,
  input  logic [LAP_AW-1:0] rd_idx,
  output logic [23:0]       time_bcd,
  output logic [23:0]       lap_bcd,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              running,
  output logic              done,
  output logic              ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [23:0] TIME_MAX = 24'h995999;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [23:0]         time_q, time_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [LAP_AW-1:0]   wptr_q, wptr_d;
  logic [LAP_AW:0]     cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [23:0]         lap_q;
  logic [23:0]         mem_q [LAP_DEPTH];

  // Digit index 3 is tens-of-seconds (0-5); all other digits run 0-9.
  function automatic logic [23:0] bcd_step(input logic [23:0] t, input logic down);
    logic [23:0] r;
    logic        c;
    logic [3:0]  d, mx;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mx = (i == 3) ? 4'd5 : 4'd9;
      d  = t[i*4 +: 4];
      if (c) begin
        if (!down) begin
          if (d >= mx) begin d = 4'd0; c = 1'b1; end
          else begin d = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) begin d = mx; c = 1'b1; end
          else begin d = d - 4'd1; c = 1'b0; end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_clamp(input logic [23:0] t);
    logic [23:0] r;
    logic [3:0]  mx;
    r = t;
    for (int i = 0; i < 6; i++) begin
      mx = (i == 3) ? 4'd5 : 4'd9;
      if (t[i*4 +: 4] > mx) r[i*4 +: 4] = mx;
    end
    return r;
  endfunction

  logic              do_clr, do_load, do_ss, do_lap, tick, hit_zero;
  logic [23:0]       time_step;
  logic [LAP_AW-1:0] oldest, rd_addr;

  assign do_clr    = clear_p;
  assign do_load   = !clear_p && load_p && (state_q != RUN);
  assign do_ss     = !clear_p && !load_p && start_stop_p;
  assign do_lap    = !clear_p && !load_p && !start_stop_p && lap_p &&
                     ((state_q == RUN) || (state_q == PAUSE));
  assign tick      = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign time_step = bcd_step(time_q, dir_q);
  assign hit_zero  = dir_q && ((time_step == 24'h0) || (time_q == 24'h0));
  assign oldest    = (cnt_q == (LAP_AW+1)'(LAP_DEPTH)) ? wptr_q : '0;
  assign rd_addr   = oldest + rd_idx;

  always_ff @(posedge mclk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (do_clr) begin
      state_d = IDLE;
    end else if (do_load) begin
      if (state_q == DONE) state_d = IDLE;
    end else begin
      if (do_ss) begin
        case (state_q)
          IDLE:    if (!(mode && time_q == 24'h0)) state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = state_q;
        endcase
      end
      // Reaching zero while counting down ends the run even if a pause arrives together.
      if (tick && hit_zero) state_d = DONE;
    end
  end

  always_comb begin
    running   = (state_q == RUN);
    time_bcd  = time_q;
    lap_bcd   = lap_q;
    lap_count = cnt_q;
    lap_full  = full_q;
    done      = done_q;
    ovf       = ovf_q;
  end

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    dir_d   = (state_q == IDLE) ? mode : dir_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (do_clr) begin
      presc_d = '0;
      time_d  = 24'h0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      wptr_d  = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
    end else if (do_load) begin
      presc_d = '0;
      time_d  = bcd_clamp(load_val);
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (state_q == RUN) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        time_d = (dir_q && time_q == 24'h0) ? time_q : time_step;
        if (hit_zero) done_d = 1'b1;
        if (!dir_q && time_q == TIME_MAX) ovf_d = 1'b1;
      end
      if (do_lap) begin
        wptr_d = wptr_q + 1'b1;
        if (cnt_q == (LAP_AW+1)'(LAP_DEPTH)) full_d = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      presc_q <= '0;
      time_q  <= 24'h0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      lap_q   <= 24'h0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      lap_q   <= ({1'b0, rd_idx} < cnt_q) ? mem_q[rd_addr] : 24'h0;
    end
  end

  // Lap storage is left uncleared; lap_count gates every read.
  always_ff @(posedge mclk) begin
    if (rst && do_lap) mem_q[wptr_q] <= time_q;
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4, LAP_DEPTH=4.
module tb_stopwatch_core;

  localparam int AW = 2;
  localparam int OP_RST = 0, OP_CLR = 1, OP_LOAD = 2, OP_START = 3;

  logic          mclk = 1'b0;
  logic          rst = 1'b0;
  logic          start_stop_p = 1'b0, clear_p = 1'b0, lap_p = 1'b0, load_p = 1'b0;
  logic [23:0]   load_val = 24'h0;
  logic          mode = 1'b0;
  logic [AW-1:0] rd_idx = '0;
  logic [23:0]   time_bcd, lap_bcd;
  logic [AW:0]   lap_count;
  logic          lap_full, running, done, ovf;

  int tests = 0;
  int fails = 0;

  stopwatch_core #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
    .mclk(mclk), .rst(rst), .start_stop_p(start_stop_p), .clear_p(clear_p),
    .lap_p(lap_p), .load_p(load_p), .load_val(load_val), .mode(mode),
    .rd_idx(rd_idx), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
    .lap_count(lap_count), .lap_full(lap_full), .running(running),
    .done(done), .ovf(ovf)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int          op;
    logic [23:0] arg;
    int          wait_n;
    logic [23:0] e_time;
    logic        e_run;
    logic        e_done;
    logic        e_ovf;
    logic [2:0]  e_cnt;
    logic        e_full;
  } vec_t;

  vec_t vecs [14];

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pulse_start(input logic m);
    mode = m;
    start_stop_p = 1'b1;
    cyc();
    start_stop_p = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_p = 1'b1;
    cyc();
    clear_p = 1'b0;
  endtask

  task automatic pulse_load(input logic [23:0] v);
    load_val = v;
    load_p = 1'b1;
    cyc();
    load_p = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_p = 1'b1;
    cyc();
    lap_p = 1'b0;
  endtask

  initial begin
    //           op        arg        wait  time       run   done  ovf   cnt   full
    vecs[0]  = '{OP_RST,   24'h0,      0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{OP_START, 24'h0,    400, 24'h000100, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{OP_CLR,   24'h0,      0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{OP_LOAD,  24'h995998, 0, 24'h995998, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[4]  = '{OP_START, 24'h0,      8, 24'h000000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[5]  = '{OP_CLR,   24'h0,      0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[6]  = '{OP_LOAD,  24'h000002, 0, 24'h000002, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{OP_START, 24'h1,      8, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{OP_START, 24'h1,      8, 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{OP_LOAD,  24'h000002, 0, 24'h000002, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[10] = '{OP_LOAD,  24'hFA7C3E, 0, 24'h995939, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{OP_CLR,   24'h0,      0, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[12] = '{OP_START, 24'h1,      8, 24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{OP_START, 24'h0,      4, 24'h000001, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

    #1;
    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OP_RST:  begin rst = 1'b0; cyc(); rst = 1'b1; end
        OP_CLR:  pulse_clear();
        OP_LOAD: pulse_load(vecs[i].arg);
        default: pulse_start(vecs[i].arg[0]);
      endcase
      repeat (vecs[i].wait_n) cyc();
      chk($sformatf("vec%0d time", i), time_bcd, vecs[i].e_time);
      chk($sformatf("vec%0d running", i), {23'h0, running}, {23'h0, vecs[i].e_run});
      chk($sformatf("vec%0d done", i), {23'h0, done}, {23'h0, vecs[i].e_done});
      chk($sformatf("vec%0d ovf", i), {23'h0, ovf}, {23'h0, vecs[i].e_ovf});
      chk($sformatf("vec%0d lap_count", i), {21'h0, lap_count}, {21'h0, vecs[i].e_cnt});
      chk($sformatf("vec%0d lap_full", i), {23'h0, lap_full}, {23'h0, vecs[i].e_full});
    end

    // Five laps, one tick apart: lap at start-edge+4+4k captures k centiseconds.
    pulse_clear();
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      repeat (3) cyc();
      pulse_lap();
    end
    chk("lap count after wrap", {21'h0, lap_count}, 24'd4);
    chk("lap full after wrap", {23'h0, lap_full}, 24'd1);
    for (int i = 0; i < 4; i++) begin
      rd_idx = AW'(i);
      cyc();
      chk($sformatf("lap rd_idx %0d", i), lap_bcd, 24'(i + 1));
    end
    rd_idx = '0;
    cyc();

    // Reset during RUN with competing pulses.
    rst = 1'b0;
    start_stop_p = 1'b1;
    lap_p = 1'b1;
    cyc();
    rst = 1'b1;
    start_stop_p = 1'b0;
    lap_p = 1'b0;
    chk("rst time", time_bcd, 24'h0);
    chk("rst lap_bcd", lap_bcd, 24'h0);
    chk("rst lap_count", {21'h0, lap_count}, 24'h0);
    chk("rst flags", {20'h0, lap_full, running, done, ovf}, 24'h0);
    repeat (8) cyc();
    chk("post-rst idle time", time_bcd, 24'h0);
    chk("post-rst lap_bcd", lap_bcd, 24'h0);

    // Pause with prescaler at 2, resume: update lands two edges after resume.
    pulse_start(1'b0);
    cyc();
    pulse_start(1'b0);
    repeat (5) cyc();
    chk("paused time", time_bcd, 24'h0);
    chk("paused running", {23'h0, running}, 24'h0);
    pulse_start(1'b0);
    chk("resume running", {23'h0, running}, 24'h1);
    cyc();
    chk("resume +1 time", time_bcd, 24'h0);
    cyc();
    chk("resume +2 time", time_bcd, 24'h000001);

    // Clear and start together in IDLE: clear wins.
    pulse_clear();
    pulse_load(24'h123456);
    chk("preload time", time_bcd, 24'h123456);
    clear_p = 1'b1;
    start_stop_p = 1'b1;
    cyc();
    clear_p = 1'b0;
    start_stop_p = 1'b0;
    chk("clr+start time", time_bcd, 24'h0);
    chk("clr+start running", {23'h0, running}, 24'h0);
    repeat (8) cyc();
    chk("clr+start stays idle", {23'h0, running}, 24'h0);
    chk("clr+start time held", time_bcd, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
